// File: rtl/qam16_mapper_mixer_if.sv
// Symbol handshake, NCO carrier input and modulated output stream of the QAM16 mapper/mixer.
interface qam16_mapper_mixer_if #(
  parameter int CAR_W = 10,
  parameter int OUT_W = 13
);
  logic                    sym_valid;
  logic                    sym_ready;
  logic [3:0]              sym_in;
  logic                    nco_valid;
  logic signed [CAR_W-1:0] sin;
  logic signed [CAR_W-1:0] cos;
  logic signed [OUT_W-1:0] mod_out;
  logic                    mod_valid;
  logic                    sym_start;
  logic                    underflow;

  modport master (
    output sym_in, sym_valid, nco_valid, sin, cos,
    input  sym_ready, mod_out, mod_valid, sym_start, underflow
  );

  modport slave (
    input  sym_in, sym_valid, nco_valid, sin, cos,
    output sym_ready, mod_out, mod_valid, sym_start, underflow
  );
endinterface

// File: rtl/qam16_mapper_mixer.sv
// QAM16 mapper + carrier mixer: holds each symbol for SPS NCO samples, emits I*cos - Q*sin.
// Define QAM_GRAY_EN for Gray-coded level mapping (natural binary otherwise).
module qam16_mapper_mixer #(
  parameter int SPS   = 16,
  parameter int CAR_W = 10,
  parameter int OUT_W = 13
) (
  input  logic clk,
  input  logic rst,
  qam16_mapper_mixer_if.slave bus
);
  localparam int CW     = $clog2(SPS);
  localparam int PW     = CAR_W + 3;
  localparam int STAGES = 3;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [2:0]       i_lvl_q, i_lvl_d, q_lvl_q, q_lvl_d;
  logic                    start_q, start_d;
  logic                    uf_q, uf_d;
  logic                    last, xfer;

  logic [STAGES:0]         vld_pipe, st_pipe;
  logic [STAGES:1]         vld_q, st_q;
  logic signed [2:0]       i1_q, q1_q;
  logic signed [CAR_W-1:0] sin1_q, cos1_q;
  logic signed [PW-1:0]    pi_q, pq_q, pi_d, pq_d;
  logic signed [OUT_W-1:0] out_q, out_d;

  function automatic logic signed [2:0] map2(input logic [1:0] b);
    logic signed [2:0] l;
    l = 3'sd0;
`ifdef QAM_GRAY_EN
    case (b)
      2'b00:   l = -3'sd3;
      2'b01:   l = -3'sd1;
      2'b11:   l = 3'sd1;
      default: l = 3'sd3;
    endcase
`else
    case (b)
      2'b00:   l = -3'sd3;
      2'b01:   l = -3'sd1;
      2'b10:   l = 3'sd1;
      default: l = 3'sd3;
    endcase
`endif
    return l;
  endfunction

  // The boundary is the nco_valid cycle carrying the last sample of the held symbol.
  assign last          = (state_q == RUN) && bus.nco_valid && (cnt_q == CW'(SPS-1));
  assign bus.sym_ready = (state_q == IDLE) || last;
  assign xfer          = bus.sym_valid && bus.sym_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = RUN;
      RUN:     if (last && !xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    i_lvl_d = i_lvl_q;
    q_lvl_d = q_lvl_q;
    start_d = start_q;
    uf_d    = 1'b0;
    if (bus.nco_valid) start_d = 1'b0;
    if (state_q == RUN && bus.nco_valid) cnt_d = last ? '0 : cnt_q + CW'(1);
    if (xfer) begin
      cnt_d   = '0;
      i_lvl_d = map2(bus.sym_in[3:2]);
      q_lvl_d = map2(bus.sym_in[1:0]);
      start_d = 1'b1;
    end else if (last) begin
      i_lvl_d = '0;
      q_lvl_d = '0;
      uf_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      i_lvl_q <= '0;
      q_lvl_q <= '0;
      start_q <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      i_lvl_q <= i_lvl_d;
      q_lvl_q <= q_lvl_d;
      start_q <= start_d;
      uf_q    <= uf_d;
    end
  end

  assign vld_pipe = {vld_q, bus.nco_valid};
  assign st_pipe  = {st_q, start_q & bus.nco_valid};
  assign pi_d     = PW'(i1_q) * PW'(cos1_q);
  assign pq_d     = PW'(q1_q) * PW'(sin1_q);
  assign out_d    = OUT_W'(pi_q) - OUT_W'(pq_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      st_q   <= '0;
      i1_q   <= '0;
      q1_q   <= '0;
      sin1_q <= '0;
      cos1_q <= '0;
      pi_q   <= '0;
      pq_q   <= '0;
      out_q  <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      st_q  <= st_pipe[STAGES-1:0];
      if (bus.nco_valid) begin
        i1_q   <= i_lvl_q;
        q1_q   <= q_lvl_q;
        sin1_q <= bus.sin;
        cos1_q <= bus.cos;
      end
      pi_q  <= pi_d;
      pq_q  <= pq_d;
      out_q <= out_d;
    end
  end

  assign bus.mod_out   = out_q;
  assign bus.mod_valid = vld_pipe[STAGES];
  assign bus.sym_start = st_pipe[STAGES];
  assign bus.underflow = uf_q;
endmodule

// File: tb/tb_qam16_mapper_mixer.sv
// Directed bench for qam16_mapper_mixer; expected levels follow QAM_GRAY_EN when defined.
module tb_qam16_mapper_mixer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

`ifdef QAM_GRAY_EN
  localparam int E_F511 = 511;   // 4'b1111 -> I=+1
  localparam int E_F200 = 200;
  localparam int E_F100 = 100;
  localparam int E_8100 = 300;   // 4'b1000 -> I=+3
`else
  localparam int E_F511 = 1533;
  localparam int E_F200 = 600;
  localparam int E_F100 = 300;
  localparam int E_8100 = 100;
`endif

  qam16_mapper_mixer_if #(.CAR_W(10), .OUT_W(13)) bus ();

  qam16_mapper_mixer #(.SPS(16), .CAR_W(10), .OUT_W(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One symbol with continuous nco_valid, followed by an underflow back to idle.
  task automatic run_single(input logic [3:0] sym, input int c, input int s, input int exp);
    bus.sym_in = sym; bus.sym_valid = 1'b1; bus.cos = 10'(c); bus.sin = 10'(s);
    bus.nco_valid = 1'b1;
    #1;
    chk("ready_idle", int'(bus.sym_ready), 1);
    step();
    bus.sym_valid = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      step();
      chk("uf", int'(bus.underflow), int'(j == 16));
      if (j >= 3) begin
        chk("vld", int'(bus.mod_valid), 1);
        chk("out", int'(bus.mod_out), (j <= 18) ? exp : 0);
        chk("start", int'(bus.sym_start), int'(j == 3));
      end
    end
    chk("ready_after", int'(bus.sym_ready), 1);
  endtask

  initial begin
    bus.sym_in = 4'h0; bus.sym_valid = 1'b0; bus.nco_valid = 1'b1;
    bus.sin = '0; bus.cos = '0;

    // 1: reset with nco_valid toggling
    for (int k = 0; k < 2; k++) begin
      step();
      bus.nco_valid = ~bus.nco_valid;
      chk("rst_vld", int'(bus.mod_valid), 0);
      chk("rst_out", int'(bus.mod_out), 0);
      chk("rst_uf", int'(bus.underflow), 0);
      chk("rst_start", int'(bus.sym_start), 0);
    end
    rst = 1'b0; bus.nco_valid = 1'b0;
    step();
    chk("rdy_rel", int'(bus.sym_ready), 1);
    for (int k = 0; k < 3; k++) step();

    // 2, 3: single symbols
    run_single(4'b1111, 511, 0, E_F511);
    run_single(4'b0000, 0, 100, 300);

    // 4: back-to-back symbols with sym_valid held
    bus.sym_in = 4'b1111; bus.sym_valid = 1'b1; bus.cos = 10'sd200; bus.sin = '0;
    #1;
    step();
    bus.sym_in = 4'b0000;
    for (int j = 1; j <= 36; j++) begin
      step();
      if (j <= 16) chk("b2b_rdy", int'(bus.sym_ready), int'(j == 15));
      if (j == 16) bus.sym_valid = 1'b0;
      chk("b2b_uf", int'(bus.underflow), int'(j == 32));
      if (j >= 3 && j <= 34) begin
        chk("b2b_vld", int'(bus.mod_valid), 1);
        chk("b2b_out", int'(bus.mod_out), (j <= 18) ? E_F200 : -600);
        chk("b2b_start", int'(bus.sym_start), int'(j == 3 || j == 19));
      end
    end

    // 5: 50% nco_valid duty
    bus.nco_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    bus.sym_in = 4'b1111; bus.sym_valid = 1'b1; bus.cos = 10'sd100; bus.sin = '0;
    step();
    bus.sym_valid = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      bus.nco_valid = (j % 2 == 1);
      step();
      chk("duty_vld", int'(bus.mod_valid), int'(j >= 3 && j % 2 == 1));
      chk("duty_start", int'(bus.sym_start), int'(j == 3));
      chk("duty_uf", int'(bus.underflow), int'(j == 31));
      if (j >= 3 && j % 2 == 1) chk("duty_out", int'(bus.mod_out), (j <= 33) ? E_F100 : 0);
    end

    // 6: mapping of 4'b1000
    run_single(4'b1000, 100, 0, E_8100);

    // 7: reset mid-symbol at cnt=7
    bus.sym_in = 4'b1111; bus.sym_valid = 1'b1; bus.cos = 10'sd511; bus.sin = '0;
    bus.nco_valid = 1'b1;
    step();
    bus.sym_valid = 1'b0;
    for (int j = 1; j <= 7; j++) step();
    chk("pre_rst_out", int'(bus.mod_out), E_F511);
    rst = 1'b1;
    step();
    chk("mid_rst_out", int'(bus.mod_out), 0);
    chk("mid_rst_vld", int'(bus.mod_valid), 0);
    chk("mid_rst_start", int'(bus.sym_start), 0);
    chk("mid_rst_uf", int'(bus.underflow), 0);
    chk("mid_rst_rdy", int'(bus.sym_ready), 1);
    rst = 1'b0;
    for (int j = 1; j <= 24; j++) begin
      step();
      chk("post_rst_uf", int'(bus.underflow), 0);
      chk("post_rst_vld", int'(bus.mod_valid), int'(j >= 3));
      chk("post_rst_start", int'(bus.sym_start), 0);
      chk("post_rst_out", int'(bus.mod_out), 0);
    end
    chk("post_rst_rdy", int'(bus.sym_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
